// File: rtl/channel_frame_scheduler.sv
// Round-robin frame read scheduler: arbitrates full channel FIFOs, requests a link slot, streams one framed burst.
// Optional grant-wait timeout enabled by defining FRAME_TIMEOUT_EN.
module channel_frame_scheduler #(
  parameter int NUM_CH      = 6,
  parameter int DATA_W      = 16,
  parameter int FRAME_LEN   = 128,
  parameter int RD_LAT      = 2,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic                     clk_in,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        fifo_full,
  input  logic [NUM_CH*DATA_W-1:0] fifo_data,
  output logic [NUM_CH-1:0]        fifo_rdreq,
  output logic                     frame_req,
  input  logic                     frame_ack,
  output logic [DATA_W-1:0]        data_out,
  output logic                     data_valid,
  output logic                     sof,
  output logic                     eof,
  output logic [2:0]               ch_id,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int CNT_W = $clog2(FRAME_LEN) + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    REQ   = 3'd2,
    READ  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t             state_r, state_s;
  logic [2:0]         last_ch_r;
  logic [2:0]         win_s;
  logic               win_ok_s;
  logic [CNT_W-1:0]   cnt_r;
  logic [RD_LAT-1:0]  mark_r, sof_mark_r, eof_mark_r;
  logic               rd_now_s;
  logic               to_expire_s;

  assign rd_now_s = |fifo_rdreq;

  // Winner search: lowest offset from last_ch wins, offset NUM_CH (last_ch itself) is lowest priority.
  always_comb begin
    int idx;
    idx      = 0;
    win_s    = 3'd0;
    win_ok_s = 1'b0;
    for (int i = NUM_CH; i >= 1; i--) begin
      idx = int'(last_ch_r) + i;
      idx = (idx >= NUM_CH) ? (idx - NUM_CH) : idx;
      if (fifo_full[idx]) begin
        win_s    = 3'(idx);
        win_ok_s = 1'b1;
      end else begin
        win_s    = win_s;
        win_ok_s = win_ok_s;
      end
    end
  end

`ifdef FRAME_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_r;

  assign to_expire_s = (state_r == REQ) && !frame_ack && (to_cnt_r == TO_W'(TIMEOUT_CYC - 1));

  // Grant-wait counter and one-cycle timeout pulse.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      to_cnt_r    <= '0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt_r    <= (state_r == REQ) ? (to_cnt_r + 1'b1) : '0;
      timeout_err <= to_expire_s;
    end
  end
`else
  assign to_expire_s = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:  state_s = (|fifo_full) ? ARB : IDLE;
      ARB:   state_s = win_ok_s ? REQ : IDLE;
      REQ: begin
        if (frame_ack) begin
          state_s = READ;
        end else if (to_expire_s) begin
          state_s = IDLE;
        end else begin
          state_s = REQ;
        end
      end
      READ:  state_s = (cnt_r == CNT_W'(FRAME_LEN - 1)) ? DRAIN : READ;
      DRAIN: state_s = eof ? IDLE : DRAIN;
      default: state_s = IDLE;
    endcase
  end

  // State, control outputs, channel bookkeeping and word counter.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_r    <= IDLE;
      busy       <= 1'b0;
      frame_req  <= 1'b0;
      fifo_rdreq <= '0;
      ch_id      <= 3'd0;
      last_ch_r  <= 3'(NUM_CH - 1);
      cnt_r      <= '0;
    end else begin
      state_r    <= state_s;
      busy       <= (state_s != IDLE);
      frame_req  <= (state_s == REQ);
      fifo_rdreq <= (state_s == READ) ? ({{(NUM_CH-1){1'b0}}, 1'b1} << ch_id) : '0;
      if ((state_r == ARB) && win_ok_s) begin
        ch_id <= win_s;
      end else begin
        ch_id <= ch_id;
      end
      // A timed-out channel also becomes last_ch so it yields to the others.
      if (((state_r == DRAIN) && eof) || to_expire_s) begin
        last_ch_r <= ch_id;
      end else begin
        last_ch_r <= last_ch_r;
      end
      if ((state_r == REQ) && frame_ack) begin
        cnt_r <= '0;
      end else if (state_r == READ) begin
        cnt_r <= cnt_r + 1'b1;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Read-latency pipeline and framed output register.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      mark_r     <= '0;
      sof_mark_r <= '0;
      eof_mark_r <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      sof        <= 1'b0;
      eof        <= 1'b0;
    end else begin
      mark_r[0]     <= rd_now_s;
      sof_mark_r[0] <= rd_now_s && (cnt_r == CNT_W'(0));
      eof_mark_r[0] <= rd_now_s && (cnt_r == CNT_W'(FRAME_LEN - 1));
      for (int i = 1; i < RD_LAT; i++) begin
        mark_r[i]     <= mark_r[i-1];
        sof_mark_r[i] <= sof_mark_r[i-1];
        eof_mark_r[i] <= eof_mark_r[i-1];
      end
      data_valid <= mark_r[RD_LAT-1];
      data_out   <= mark_r[RD_LAT-1] ? fifo_data[ch_id*DATA_W +: DATA_W] : '0;
      sof        <= mark_r[RD_LAT-1] && sof_mark_r[RD_LAT-1];
      eof        <= mark_r[RD_LAT-1] && eof_mark_r[RD_LAT-1];
    end
  end

endmodule

// File: doc/channel_frame_scheduler.md
Name: channel_frame_scheduler

Overview:
- Round-robin frame read scheduler for the per-channel peak-data FIFOs.
- Watches each channel's FIFO-full flag and requests the downstream link (communication_fpga) for a slot.
- Once granted, reads exactly one FRAME_LEN-word frame from the chosen FIFO.
- Emits the frame as a framed stream with channel ID, sof, eof and valid; replaces manual per-channel rdreq sequencing.

Parameters:
NUM_CH, 6, number of channel FIFOs (2..8)
DATA_W, 16, FIFO word width
FRAME_LEN, 128, words per frame (2..256)
RD_LAT, 2, cycles from fifo_rdreq high to valid word on fifo_data (1..3)
TIMEOUT_CYC, 1023, grant wait limit; used only with FRAME_TIMEOUT_EN

Ports:
clk_in  in  1  module clock
rst  in  1  synchronous reset, active-high
fifo_full  in  NUM_CH  per-channel FIFO-full flag, level
fifo_data  in  NUM_CH*DATA_W  flat FIFO read data; channel k at bits [k*DATA_W +: DATA_W]
fifo_rdreq  out  NUM_CH  per-channel read request, one-hot or zero
frame_req  out  1  request to downstream link for a frame slot
frame_ack  in  1  downstream grant, single-cycle pulse
data_out  out  DATA_W  frame word
data_valid  out  1  data_out qualifier
sof  out  1  with first valid word of frame
eof  out  1  with last valid word of frame
ch_id  out  3  channel of current frame; stable from frame_req rise to eof
busy  out  1  high in every state except IDLE
timeout_err  out  1  one-cycle pulse; only with FRAME_TIMEOUT_EN, else tied 0

Behaviour:
- Single clock domain, clk_in. All logic is synchronous to clk_in.
- rst is synchronous and active-high.
- Reset state:
  - FSM in IDLE.
  - All outputs 0.
  - Round-robin pointer last_ch = NUM_CH-1, so channel 0 wins first.
  - Word counter and latency pipeline cleared.
- Reset mid-frame: fifo_rdreq, data_valid and eof go low on the next edge. No partial-frame completion.
- FSM states: IDLE, ARB, REQ, READ, DRAIN.
- IDLE:
  - Goes to ARB when any fifo_full bit is high.
- ARB, one cycle:
  - Picks the first set bit scanning last_ch+1, last_ch+2, ... with modulo NUM_CH wrap.
  - Latches the winner into ch_id and goes to REQ.
  - If no bit is still set, returns to IDLE.
- REQ:
  - frame_req held high.
  - On frame_ack: frame_req drops next edge, cnt = 0, goes to READ.
  - frame_ack in any other state is ignored.
- READ:
  - fifo_rdreq[ch_id] high for exactly FRAME_LEN consecutive cycles; cnt counts 0..FRAME_LEN-1.
  - On the last rdreq cycle, goes to DRAIN.
  - A selected fifo_full deasserting mid-frame is ignored; the frame always completes.
- DRAIN:
  - Waits until the last word is output, then sets last_ch = ch_id and returns to IDLE.
  - A new ARB therefore starts at least 1 cycle after eof.
- Latency pipeline:
  - A rdreq-shift register of depth RD_LAT marks the sample cycle.
  - fifo_data slice ch_id is registered into data_out when the mark exits.
  - data_out / data_valid appear RD_LAT+1 cycles after the matching fifo_rdreq cycle.
  - A frame gives exactly FRAME_LEN consecutive valid cycles with no gaps.
- data_out = 0 whenever data_valid = 0.
- sof is asserted with word 0 and eof with word FRAME_LEN-1, each qualified by data_valid.
- Counter width is clog2(FRAME_LEN)+1. Channel index arithmetic is modulo NUM_CH, never a power-of-2 wrap.
- Simultaneous full flags: served strictly round-robin, one frame each. No channel is served twice while another is pending.
- fifo_rdreq is never asserted outside READ and is never multi-hot.

Optional Feature:
- Macro: FRAME_TIMEOUT_EN.
- With the macro defined:
  - REQ counts cycles.
  - If frame_ack is absent for TIMEOUT_CYC cycles: frame_req drops, timeout_err pulses 1 cycle, last_ch = ch_id (channel skipped this round), and the FSM goes to IDLE.
  - No FIFO read occurs on timeout.
- Without the macro:
  - REQ waits indefinitely.
  - timeout_err is constant 0 and no timeout counter is synthesized.

Test Plan:
- Reset then fifo_full=6'b000100, frame_ack 3 cycles after frame_req:
  - ch_id=2, and fifo_rdreq[2] is high exactly 128 cycles.
  - data_valid is high 128 cycles starting RD_LAT+1=3 cycles after the first rdreq, with sof on word 0 and eof on word 127.
  - data_out matches the FIFO model sequence 0..127.
- fifo_full=6'b111111 held, frame_ack immediate:
  - Frames served on channels 0,1,2,3,4,5,0 in order.
  - fifo_rdreq is never multi-hot.
- fifo_full[1] high, drops to 0 after 10 read cycles:
  - The frame still completes with 128 words.
  - Scheduler returns to IDLE.
- rst asserted on read word 60:
  - Next edge: all fifo_rdreq, data_valid, eof and frame_req are 0, and busy=0.
  - After release with fifo_full=6'b000001, ch_id=0.
- frame_ack pulsed while in IDLE:
  - No state change and no rdreq.
- FRAME_TIMEOUT_EN, TIMEOUT_CYC=20, no frame_ack, fifo_full=6'b000011:
  - timeout_err pulses 20 cycles after frame_req rises, with no rdreq.
  - The next frame_req is for ch_id=1.
